// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master arbiter sharing one synchronous RAM through an issue/wait/response FSM.
// Optional grant/conflict counters are compiled in when MEM_BUS_ARBITER_STATS_EN is defined.
module mem_bus_arbiter #(
    parameter int unsigned MEM_LAT   = 1,
    parameter bit          PRIO_MODE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic        busy
`ifdef MEM_BUS_ARBITER_STATS_EN
    ,
    output logic [31:0] stat_m0_grants,
    output logic [31:0] stat_m1_grants,
    output logic [31:0] stat_conflicts
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d, last_q, last_d, win, any_req;
    logic [3:0]  cnt_q, cnt_d, be_q, be_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rd0_q, rd0_d, rd1_q, rd1_d;

    assign any_req = m0_req | m1_req;
    // round-robin favours whoever did not win last; fixed priority always favours m0
    assign win = (m0_req & m1_req) ? (PRIO_MODE ? 1'b0 : ~last_q) : m1_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        case (state_q)
            IDLE: if (any_req) begin
                state_d = ISSUE;
                gnt_d   = win;
                last_d  = win;
                addr_d  = win ? m1_addr : m0_addr;
                wdata_d = win ? m1_wdata : m0_wdata;
                be_d    = win ? m1_be : m0_be;
            end
            ISSUE: begin
                cnt_d   = 4'(MEM_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    rd0_d   = (be_q == 4'd0 && !gnt_q) ? mem_rdata : rd0_q;
                    rd1_d   = (be_q == 4'd0 && gnt_q) ? mem_rdata : rd1_q;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_en    = state_q == ISSUE;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign m0_ack    = state_q == RESP && !gnt_q;
    assign m1_ack    = state_q == RESP && gnt_q;
    assign m0_rdata  = rd0_q;
    assign m1_rdata  = rd1_q;
    assign busy      = state_q != IDLE;

`ifdef MEM_BUS_ARBITER_STATS_EN
    logic [31:0] g0_q, g1_q, cf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            g0_q <= '0;
            g1_q <= '0;
            cf_q <= '0;
        end else if (state_q == IDLE) begin
            if (any_req && !win && g0_q != '1) g0_q <= g0_q + 32'd1;
            if (any_req && win && g1_q != '1) g1_q <= g1_q + 32'd1;
            if (m0_req && m1_req && cf_q != '1) cf_q <= cf_q + 32'd1;
        end
    end

    assign stat_m0_grants = g0_q;
    assign stat_m1_grants = g1_q;
    assign stat_conflicts = cf_q;
`endif
endmodule
